mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one downstream memory port between the core's instruction-fetch port (I) and data port (D).
- Sits between the pipelined CPU core and the memory/cache interconnect.
- Grants one transaction at a time, holds it until completion, and routes the handshakes and read data back to the owner.
- The I port is read-only. The D port carries reads and writes.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width. Strobe width is DATA_W/8.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- i_valid  in  1  instruction request valid.
- i_addr  in  ADDR_W  instruction address.
- i_addr_ok  out  1  instruction address accepted.
- i_data_ok  out  1  instruction data returned.
- i_data  out  DATA_W  instruction read data.
- d_valid  in  1  data request valid.
- d_addr  in  ADDR_W  data address.
- d_size  in  3  access size code, passed through unchanged.
- d_strobe  in  DATA_W/8  byte write enables; all zero means read.
- d_wdata  in  DATA_W  write data.
- d_addr_ok  out  1  data address accepted.
- d_data_ok  out  1  data returned or write done.
- d_data  out  DATA_W  data read data.
- m_valid  out  1  downstream request valid.
- m_addr  out  ADDR_W  downstream address.
- m_size  out  3  downstream size.
- m_strobe  out  DATA_W/8  downstream strobes.
- m_wdata  out  DATA_W  downstream write data.
- m_addr_ok  in  1  downstream address accepted.
- m_data_ok  in  1  downstream data or completion.
- m_data  in  DATA_W  downstream read data.

Behaviour:
- Requester contract: valid and payload are held stable until that port's data_ok.
- States: IDLE, ADDR (m_valid=1, waiting for m_addr_ok), DATA (waiting for m_data_ok). An owner register records I or D.
- IDLE: if any valid is high, pick a winner, latch its payload into m_* registers, set owner, and go to ADDR.
  - The I request is latched with size=3'b010 and strobe=0.
  - Fixed priority: D beats I when both are valid.
  - Downstream m_valid first rises the cycle after the grant (one-cycle grant latency).
- ADDR:
  - m_addr_ok=0: stay in ADDR.
  - m_addr_ok=1, m_data_ok=0: go to DATA.
  - m_addr_ok=1, m_data_ok=1: go to IDLE.
  - m_valid drops on the cycle after m_addr_ok.
- DATA:
  - m_data_ok=1: go to IDLE.
  - Otherwise stay in DATA.
- Response routing is combinational:
  - owner's addr_ok = m_addr_ok while in ADDR.
  - owner's data_ok = m_data_ok while in ADDR or DATA.
  - owner's data = m_data.
  - The non-owner's addr_ok and data_ok are 0. Both data outputs may always carry m_data.
- Back-to-back: after completion the FSM returns to IDLE, so there is one idle cycle between downstream transactions.
- m_addr_ok or m_data_ok arriving in IDLE: ignored; no owner handshake is generated.
- Request dropped before grant: never granted.
- Reset, including mid-transaction:
  - Next cycle: state=IDLE, owner=I, m_valid=0, m_addr/m_size/m_strobe/m_wdata=0.
  - All *_addr_ok and *_data_ok outputs are 0.
  - Any in-flight downstream transaction is abandoned; the downstream side is reset in the same cycle.
- The arbiter never modifies addresses or data. Width conversion is not this block's job.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last_owner register, reset to I, is updated on each grant. On simultaneous I and D requests in IDLE, the port that was not last_owner wins. Single requests are granted as usual.
- Undefined: fixed D-over-I priority as described above. No last_owner register is built.

Test Plan:
- Single I read: i_valid=1, i_addr=32'hbfc0_0000, downstream replies addr_ok at cycle 2 and data_ok at cycle 4 with 32'h2408_0001 -> m_valid high cycles 1-2 with m_addr=32'hbfc0_0000 and m_strobe=0; i_addr_ok pulses cycle 2; i_data_ok pulses cycle 4 with i_data=32'h2408_0001; d_* stay 0.
- D write: d_addr=32'h8000_0010, d_strobe=4'b1111, d_wdata=32'hdead_beef, downstream returns addr_ok and data_ok together at cycle 1 -> m_* carry the D payload; d_addr_ok and d_data_ok both pulse in cycle 1; FSM is in IDLE at cycle 2.
- Simultaneous I and D, macro undefined, held for two transactions -> D granted first, I second with exactly one idle cycle between downstream transactions; i_addr_ok=0 during the D transaction.
- Simultaneous I and D, MEM_ARB_RR_EN defined, three contended grants -> order D, I, D after reset (last_owner=I at reset).
- Reset asserted while in DATA waiting for data_ok -> next cycle m_valid=0 and all ok outputs 0; a late m_data_ok after reset produces no i_data_ok or d_data_ok.
- Downstream stalls addr_ok for 5 cycles -> m_valid and m_addr stay stable for all 5 cycles; a new i_valid arriving meanwhile is not granted until completion.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one downstream memory port between the core's instruction-fetch
// port (I, read-only) and data port (D, read/write). One transaction is
// granted at a time and held until the downstream side signals completion.
// Handshakes and read data are routed back to whichever port owns it.
//
// Optional build macro:
//   MEM_ARB_RR_EN  - defined: round-robin between I and D on contention.
//                    undefined: fixed priority, D beats I.
//
// Parameters:
//   ADDR_W  address width of all ports
//   DATA_W  data width; strobe width is DATA_W/8
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   i_valid/i_addr                   instruction request
//   i_addr_ok/i_data_ok/i_data       instruction handshakes and read data
//   d_valid/d_addr/d_size/d_strobe/d_wdata
//                                    data request (strobe == 0 means read)
//   d_addr_ok/d_data_ok/d_data       data handshakes and read data
//   m_valid/m_addr/m_size/m_strobe/m_wdata
//                                    downstream request
//   m_addr_ok/m_data_ok/m_data       downstream handshakes and read data
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_data,

  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2:0]          d_size,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_data,

  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [2:0]          m_size,
  output logic [DATA_W/8-1:0] m_strobe,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_data
);

  localparam int STRB_W = DATA_W / 8;

  // Owner encoding: 0 = instruction port, 1 = data port.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Instruction fetches are always full-word reads.
  localparam logic [2:0] I_SIZE = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t              state;
  state_t              stateNext;
  logic                owner;
  logic                grant;
  logic                winner;

  logic [ADDR_W-1:0]   addrQ;
  logic [2:0]          sizeQ;
  logic [STRB_W-1:0]   strobeQ;
  logic [DATA_W-1:0]   wdataQ;

  // Winner selection on contention.
`ifdef MEM_ARB_RR_EN
  logic lastOwner;

  // On a simultaneous request the port that was not served last wins.
  always_comb begin
    if (i_valid && d_valid) begin
      winner = ~lastOwner;
    end else begin
      winner = d_valid ? OWN_D : OWN_I;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lastOwner <= OWN_I;
    end else if (grant) begin
      lastOwner <= winner;
    end
  end
`else
  always_comb begin
    winner = d_valid ? OWN_D : OWN_I;
  end
`endif

  // Next-state logic.
  always_comb begin
    stateNext = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid || d_valid) begin
          grant     = 1'b1;
          stateNext = ADDR;
        end
      end
      ADDR: begin
        if (m_addr_ok) begin
          stateNext = m_data_ok ? IDLE : DATA;
        end
      end
      DATA: begin
        if (m_data_ok) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, owner and latched downstream payload. The payload is reset too
  // so an abandoned transaction leaves nothing stale on the m_* bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= OWN_I;
      addrQ   <= '0;
      sizeQ   <= '0;
      strobeQ <= '0;
      wdataQ  <= '0;
    end else begin
      state <= stateNext;
      if (grant) begin
        owner <= winner;
        if (winner == OWN_D) begin
          addrQ   <= d_addr;
          sizeQ   <= d_size;
          strobeQ <= d_strobe;
          wdataQ  <= d_wdata;
        end else begin
          addrQ   <= i_addr;
          sizeQ   <= I_SIZE;
          strobeQ <= '0;
          wdataQ  <= '0;
        end
      end
    end
  end

  // Downstream request is presented only while waiting for address accept,
  // so m_valid falls the cycle after m_addr_ok.
  assign m_valid  = (state == ADDR);
  assign m_addr   = addrQ;
  assign m_size   = sizeQ;
  assign m_strobe = strobeQ;
  assign m_wdata  = wdataQ;

  // Response routing: handshakes reach only the owner, and only while a
  // transaction is in flight; pulses seen in IDLE are dropped.
  logic inAddr;
  logic inFlight;

  assign inAddr   = (state == ADDR);
  assign inFlight = (state == ADDR) || (state == DATA);

  assign i_addr_ok = inAddr   && (owner == OWN_I) && m_addr_ok;
  assign i_data_ok = inFlight && (owner == OWN_I) && m_data_ok;
  assign d_addr_ok = inAddr   && (owner == OWN_D) && m_addr_ok;
  assign d_data_ok = inFlight && (owner == OWN_D) && m_data_ok;

  assign i_data = m_data;
  assign d_data = m_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic              i_addr_ok, i_data_ok;
  logic [DATA_W-1:0] i_data;
  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_size;
  logic [STRB_W-1:0] d_strobe;
  logic [DATA_W-1:0] d_wdata;
  logic              d_addr_ok, d_data_ok;
  logic [DATA_W-1:0] d_data;
  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [2:0]        m_size;
  logic [STRB_W-1:0] m_strobe;
  logic [DATA_W-1:0] m_wdata;
  logic              m_addr_ok, m_data_ok;
  logic [DATA_W-1:0] m_data;

  int nCmp = 0;
  int nErr = 0;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .d_data(d_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_data(m_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    i_valid = 0; i_addr = '0;
    d_valid = 0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
    m_addr_ok = 0; m_data_ok = 0; m_data = '0;
  endtask

  task automatic doReset();
    idleIn();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic chkQuiet(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_i_addr_ok"}, i_addr_ok, 0);
    chk({tag, "_i_data_ok"}, i_data_ok, 0);
    chk({tag, "_d_addr_ok"}, d_addr_ok, 0);
    chk({tag, "_d_data_ok"}, d_data_ok, 0);
  endtask

  // Random-phase reference model: transaction-level view of the arbiter.
  bit                busy, acc, own, lastOwn;
  bit                iPend, dPend;
  bit                aok, dok;
  logic [ADDR_W-1:0] iA, dA, eA;
  logic [2:0]        dSz, eSz;
  logic [STRB_W-1:0] dStrb, eStrb;
  logic [DATA_W-1:0] dW, eW, md;
  bit                rr;

  initial begin
`ifdef MEM_ARB_RR_EN
    rr = 1;
`else
    rr = 0;
`endif
    doReset();

    // Reset state
    #1;
    chkQuiet("reset");
    chk("reset_m_addr", m_addr, 0);
    chk("reset_m_size", m_size, 0);
    chk("reset_m_strobe", m_strobe, 0);
    chk("reset_m_wdata", m_wdata, 0);
    tick();

    // Single I read: grant at cycle 0, addr_ok cycle 2, data_ok cycle 4
    i_valid = 1; i_addr = 32'hbfc0_0000;
    #1; chk("ird_c0_m_valid", m_valid, 0);
    tick();
    #1;
    chk("ird_c1_m_valid", m_valid, 1);
    chk("ird_c1_m_addr", m_addr, 32'hbfc0_0000);
    chk("ird_c1_m_strobe", m_strobe, 0);
    chk("ird_c1_m_size", m_size, 3'b010);
    chk("ird_c1_i_addr_ok", i_addr_ok, 0);
    tick();
    m_addr_ok = 1;
    #1;
    chk("ird_c2_m_valid", m_valid, 1);
    chk("ird_c2_i_addr_ok", i_addr_ok, 1);
    chk("ird_c2_d_addr_ok", d_addr_ok, 0);
    tick();
    m_addr_ok = 0;
    #1;
    chk("ird_c3_m_valid", m_valid, 0);
    chk("ird_c3_i_data_ok", i_data_ok, 0);
    tick();
    m_data_ok = 1; m_data = 32'h2408_0001;
    #1;
    chk("ird_c4_i_data_ok", i_data_ok, 1);
    chk("ird_c4_i_data", i_data, 32'h2408_0001);
    chk("ird_c4_d_data_ok", d_data_ok, 0);
    tick();
    idleIn();
    #1; chk("ird_c5_m_valid", m_valid, 0);
    tick();

    // D write completing with addr_ok and data_ok together
    doReset();
    d_valid = 1; d_addr = 32'h8000_0010; d_size = 3'b010;
    d_strobe = 4'b1111; d_wdata = 32'hdead_beef;
    tick();
    m_addr_ok = 1; m_data_ok = 1;
    #1;
    chk("dwr_c1_m_valid", m_valid, 1);
    chk("dwr_c1_m_addr", m_addr, 32'h8000_0010);
    chk("dwr_c1_m_strobe", m_strobe, 4'b1111);
    chk("dwr_c1_m_wdata", m_wdata, 32'hdead_beef);
    chk("dwr_c1_m_size", m_size, 3'b010);
    chk("dwr_c1_d_addr_ok", d_addr_ok, 1);
    chk("dwr_c1_d_data_ok", d_data_ok, 1);
    chk("dwr_c1_i_addr_ok", i_addr_ok, 0);
    tick();
    // Idle cycle: a stray m_data_ok must not reach either port
    d_valid = 0; m_addr_ok = 0; m_data_ok = 1;
    #1;
    chk("dwr_c2_m_valid", m_valid, 0);
    chk("dwr_c2_stray_d_data_ok", d_data_ok, 0);
    chk("dwr_c2_stray_i_data_ok", i_data_ok, 0);
    tick();
    idleIn();
    tick();

    // Simultaneous I and D
    doReset();
`ifdef MEM_ARB_RR_EN
    for (int k = 0; k < 3; k++) begin
      i_valid = 1; i_addr = 32'h1000_0000 + 32'(k);
      d_valid = 1; d_addr = 32'h2000_0000 + 32'(k); d_size = 3'b010;
      m_addr_ok = 0; m_data_ok = 0;
      #1; chk("rr_grant_m_valid", m_valid, 0);
      tick();
      m_addr_ok = 1; m_data_ok = 1;
      #1;
      chk("rr_m_addr", m_addr, (k == 1) ? 32'h1000_0001 : 32'h2000_0000 + 32'(k));
      chk("rr_i_data_ok", i_data_ok, (k == 1) ? 1 : 0);
      chk("rr_d_data_ok", d_data_ok, (k == 1) ? 0 : 1);
      tick();
    end
    idleIn();
    tick();
`else
    i_valid = 1; i_addr = 32'h1000_0040;
    d_valid = 1; d_addr = 32'h2000_0080; d_size = 3'b010;
    tick();
    m_addr_ok = 1; m_data_ok = 1;
    #1;
    chk("fix_c1_m_addr", m_addr, 32'h2000_0080);
    chk("fix_c1_d_addr_ok", d_addr_ok, 1);
    chk("fix_c1_d_data_ok", d_data_ok, 1);
    chk("fix_c1_i_addr_ok", i_addr_ok, 0);
    chk("fix_c1_i_data_ok", i_data_ok, 0);
    tick();
    d_valid = 0; m_addr_ok = 0; m_data_ok = 0;
    #1; chk("fix_c2_gap_m_valid", m_valid, 0);
    tick();
    m_addr_ok = 1; m_data_ok = 1;
    #1;
    chk("fix_c3_m_valid", m_valid, 1);
    chk("fix_c3_m_addr", m_addr, 32'h1000_0040);
    chk("fix_c3_i_addr_ok", i_addr_ok, 1);
    chk("fix_c3_i_data_ok", i_data_ok, 1);
    chk("fix_c3_d_addr_ok", d_addr_ok, 0);
    tick();
    idleIn();
    #1; chk("fix_c4_m_valid", m_valid, 0);
    tick();
`endif

    // Reset while waiting in DATA, followed by a late m_data_ok
    doReset();
    d_valid = 1; d_addr = 32'h8000_0100; d_size = 3'b001;
    d_strobe = 4'b0011; d_wdata = 32'h1234_5678;
    tick();
    m_addr_ok = 1;
    tick();
    m_addr_ok = 0;
    #1; chk("rst_data_m_valid", m_valid, 0);
    reset = 1;
    tick();
    reset = 0; idleIn(); m_data_ok = 1;
    #1;
    chkQuiet("rst_after");
    chk("rst_after_m_addr", m_addr, 0);
    chk("rst_after_m_strobe", m_strobe, 0);
    chk("rst_after_m_wdata", m_wdata, 0);
    tick();
    idleIn();
    tick();

    // Downstream stalls addr_ok for 5 cycles; I arrives meanwhile
    doReset();
    d_valid = 1; d_addr = 32'h8000_0200; d_size = 3'b010;
    tick();
    for (int c = 1; c <= 5; c++) begin
      if (c >= 2) begin i_valid = 1; i_addr = 32'hbfc0_0100; end
      #1;
      chk("stall_m_valid", m_valid, 1);
      chk("stall_m_addr", m_addr, 32'h8000_0200);
      chk("stall_i_addr_ok", i_addr_ok, 0);
      tick();
    end
    m_addr_ok = 1; m_data_ok = 1;
    #1;
    chk("stall_done_d_data_ok", d_data_ok, 1);
    chk("stall_done_i_data_ok", i_data_ok, 0);
    tick();
    d_valid = 0; m_addr_ok = 0; m_data_ok = 0;
    #1; chk("stall_gap_m_valid", m_valid, 0);
    tick();
    #1;
    chk("stall_i_m_valid", m_valid, 1);
    chk("stall_i_m_addr", m_addr, 32'hbfc0_0100);
    tick();
    idleIn();
    doReset();

    // Randomized traffic against the transaction-level model
    busy = 0; acc = 0; own = 0; lastOwn = 0; iPend = 0; dPend = 0;
    iA = '0; dA = '0; dSz = '0; dStrb = '0; dW = '0;
    eA = '0; eSz = '0; eStrb = '0; eW = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!iPend && $urandom_range(3) == 0) begin
        iPend = 1; iA = $urandom;
      end
      if (!dPend && $urandom_range(3) == 0) begin
        dPend = 1; dA = $urandom; dW = $urandom;
        dSz = 3'($urandom_range(2));
        dStrb = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
      end
      i_valid = iPend; i_addr = iA;
      d_valid = dPend; d_addr = dA; d_size = dSz; d_strobe = dStrb; d_wdata = dW;
      aok = 0; dok = 0;
      if (busy && !acc) begin
        aok = ($urandom_range(2) == 0);
        dok = aok && ($urandom_range(1) == 1);
      end else if (busy) begin
        dok = ($urandom_range(2) == 0);
      end else begin
        aok = ($urandom_range(5) == 0);
        dok = ($urandom_range(5) == 0);
      end
      md = $urandom;
      m_addr_ok = aok; m_data_ok = dok; m_data = md;
      #1;
      chk("rnd_m_valid", m_valid, busy && !acc);
      if (busy && !acc) begin
        chk("rnd_m_addr", m_addr, eA);
        chk("rnd_m_size", m_size, eSz);
        chk("rnd_m_strobe", m_strobe, eStrb);
        if (own) chk("rnd_m_wdata", m_wdata, eW);
      end
      chk("rnd_i_addr_ok", i_addr_ok, busy && !acc && !own && aok);
      chk("rnd_i_data_ok", i_data_ok, busy && !own && dok);
      chk("rnd_d_addr_ok", d_addr_ok, busy && !acc && own && aok);
      chk("rnd_d_data_ok", d_data_ok, busy && own && dok);
      if (i_data_ok) chk("rnd_i_data", i_data, md);
      if (d_data_ok) chk("rnd_d_data", d_data, md);
      tick();
      if (busy) begin
        if (aok || acc) begin
          acc = 1;
          if (dok) begin
            busy = 0;
            if (own) dPend = 0; else iPend = 0;
          end
        end
      end else if (iPend || dPend) begin
        if (iPend && dPend) own = rr ? ~lastOwn : 1'b1;
        else own = dPend;
        lastOwn = own; busy = 1; acc = 0;
        if (own) begin
          eA = dA; eSz = dSz; eStrb = dStrb; eW = dW;
        end else begin
          eA = iA; eSz = 3'b010; eStrb = '0; eW = '0;
        end
      end
    end
    idleIn();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
